shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 115 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for a 4-bit universal shift register: one parallel load,
// then a programmed number of left/right shifts (rotate or fill), then a done pulse.
module shift_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_dir,
  input  logic       cmd_rot,
  input  logic       cmd_fill,
  input  logic [2:0] cmd_cnt,
  input  logic [3:0] cmd_data,
  output logic [1:0] sr_s,
  output logic [3:0] sr_pin,
  output logic       sr_left,
  output logic       sr_right,
  input  logic [3:0] sr_q,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_RIGHT = 2'b01;
  localparam logic [1:0] SR_LEFT  = 2'b10;
  localparam logic [1:0] SR_LOAD  = 2'b11;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is high only in IDLE, so command inputs
  // on every other edge have no effect.

  state_t     state;
  logic [2:0] cnt_q;
  logic       dir_q;
  logic       rot_q;
  logic       fill_q;
  logic [3:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt_q     <= 3'd0;
      dir_q     <= 1'b0;
      rot_q     <= 1'b0;
      fill_q    <= 1'b0;
      data_q    <= 4'd0;
      sr_s      <= SR_HOLD;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= LOAD;
            cnt_q     <= cmd_cnt;
            dir_q     <= cmd_dir;
            rot_q     <= cmd_rot;
            fill_q    <= cmd_fill;
            data_q    <= cmd_data;
            sr_s      <= SR_LOAD;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end
        end
        LOAD: begin
          if (cnt_q != 3'd0) begin
            state <= SHIFT;
            sr_s  <= dir_q ? SR_LEFT : SR_RIGHT;
          end else begin
            state <= DONE;
            sr_s  <= SR_HOLD;
            done  <= 1'b1;
          end
        end
        SHIFT: begin
          // cnt_q holds the shifts still to perform, including this one.
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state <= DONE;
            sr_s  <= SR_HOLD;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          sr_s      <= SR_HOLD;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign sr_pin = data_q;

  // Only the serial input on the active shift side is driven; rotate feeds back
  // the bit leaving the opposite end of the register.
  assign sr_left  = (sr_s == SR_LEFT)  ? (rot_q ? sr_q[3] : fill_q) : 1'b0;
  assign sr_right = (sr_s == SR_RIGHT) ? (rot_q ? sr_q[0] : fill_q) : 1'b0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: a behavioural 4-bit universal shift register closes the
// loop, and final register contents are predicted from the command by plain arithmetic.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic       cmd_rot = 1'b0;
  logic       cmd_fill = 1'b0;
  logic [2:0] cmd_cnt = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic [1:0] sr_s;
  logic [3:0] sr_pin;
  logic       sr_left;
  logic       sr_right;
  logic [3:0] sr_reg = 4'd0;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  shift_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_rot(cmd_rot), .cmd_fill(cmd_fill),
    .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .sr_s(sr_s), .sr_pin(sr_pin), .sr_left(sr_left), .sr_right(sr_right),
    .sr_q(sr_reg), .busy(busy), .done(done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // external shift register driven by the controller
  always @(posedge clk) begin
    case (sr_s)
      2'b11: sr_reg <= sr_pin;
      2'b01: sr_reg <= {sr_right, sr_reg[3:1]};
      2'b10: sr_reg <= {sr_reg[2:0], sr_left};
      default: sr_reg <= sr_reg;
    endcase
  end

  // reference: result of loading data then shifting n times
  function automatic logic [3:0] ref_result(input logic d, input logic r, input logic f,
                                            input int n, input logic [3:0] data);
    int v;
    int outb;
    int fin;
    v = int'(data);
    for (int k = 0; k < n; k++) begin
      if (d) begin
        outb = (v >> 3) & 1;
        fin  = r ? outb : int'(f);
        v    = ((v << 1) & 15) | fin;
      end else begin
        outb = v & 1;
        fin  = r ? outb : int'(f);
        v    = (v >> 1) | (fin << 3);
      end
    end
    return 4'(v);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic scramble_fields();
    cmd_dir  = 1'($urandom_range(0, 1));
    cmd_rot  = 1'($urandom_range(0, 1));
    cmd_fill = 1'($urandom_range(0, 1));
    cmd_cnt  = 3'($urandom_range(0, 7));
    cmd_data = 4'($urandom_range(0, 15));
  endtask

  // driver: issue one command from IDLE and check every cycle until back in IDLE
  task automatic run_cmd(input logic d, input logic r, input logic f,
                         input logic [2:0] n, input logic [3:0] data, input logic [3:0] exp_reg);
    logic [1:0] exp_s;
    int nn;
    nn = int'(n);
    @(negedge clk);
    check("idle_before", 16'({cmd_ready, busy, done, sr_s}), 16'({1'b1, 1'b0, 1'b0, 2'b00}));
    cmd_valid = 1'b1;
    cmd_dir = d; cmd_rot = r; cmd_fill = f; cmd_cnt = n; cmd_data = data;
    exp_q.push_back(exp_reg);
    for (int i = 1; i <= nn + 2; i++) begin
      @(negedge clk);
      if (i == 1)           exp_s = 2'b11;
      else if (i <= nn + 1) exp_s = d ? 2'b10 : 2'b01;
      else                  exp_s = 2'b00;
      check("busy_cycle", 16'({cmd_ready, busy, done, sr_s, sr_pin}),
            16'({1'b0, 1'b1, (i == nn + 2), exp_s, data}));
      check("inactive_serial",
            16'({(exp_s == 2'b10) ? 1'b0 : sr_left, (exp_s == 2'b01) ? 1'b0 : sr_right}), 16'(2'b00));
      // commands offered while busy must be ignored
      scramble_fields();
      cmd_valid = (i < nn + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    @(negedge clk);
    check("idle_after", 16'({cmd_ready, busy, done, sr_s, sr_pin}), 16'({1'b1, 1'b0, 1'b0, 2'b00, data}));
    check("final_reg", 16'(sr_reg), 16'(exp_q.pop_front()));
  endtask

  typedef struct {
    logic       dir;
    logic       rot;
    logic       fill;
    logic [2:0] cnt;
    logic [3:0] data;
    logic [3:0] exp_reg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dones;
    int ready_low;
    logic rd, rr, rf;
    logic [2:0] rn;
    logic [3:0] rdat;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 4'b0110, 4'b0110};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 3'd2, 4'b1011, 4'b1100};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3'd1, 4'b1011, 4'b1101};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 3'd4, 4'b1011, 4'b1011};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd3, 4'b0001, 4'b1110};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 3'd7, 4'b1000, 4'b0100};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd7, 4'b1111, 4'b0000};

    // reset, with a command offered: reset wins
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b1; cmd_cnt = 3'd3; cmd_data = 4'b1010;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 16'({cmd_ready, busy, done, sr_s, sr_pin, sr_left, sr_right}),
          16'({1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0}));
    rst = 1'b0; cmd_valid = 1'b0;

    // directed table
    for (int v = 0; v < 7; v++)
      run_cmd(vecs[v].dir, vecs[v].rot, vecs[v].fill, vecs[v].cnt, vecs[v].data, vecs[v].exp_reg);

    // back-to-back: A (cnt 2) then B (cnt 3) with cmd_valid held
    dones = 0; ready_low = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_rot = 1'b1; cmd_fill = 1'b0; cmd_cnt = 3'd2; cmd_data = 4'b1001;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cmd_dir = 1'b1; cmd_rot = 1'b0; cmd_fill = 1'b1; cmd_cnt = 3'd3; cmd_data = 4'b0100;
      end
      if (!cmd_ready) ready_low++;
      if (done) dones++;
    end
    @(negedge clk);
    check("b2b_ready_idle", 16'(cmd_ready), 16'(1'b1));
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cmd_valid = 1'b0;
        check("b2b_load_b", 16'({sr_s, sr_pin}), 16'({2'b11, 4'b0100}));
      end
      if (done) dones++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("b2b_ready_low", 16'(ready_low), 16'd4);
    check("b2b_dones", 16'(dones), 16'd2);
    check("b2b_reg", 16'(sr_reg), 16'(ref_result(1'b1, 1'b0, 1'b1, 3, 4'b0100)));

    // reset in the 2nd SHIFT cycle of a cnt 5 command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_rot = 1'b0; cmd_fill = 1'b1; cmd_cnt = 3'd5; cmd_data = 4'b1010;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) cmd_valid = 1'b0;
    end
    check("midrst_in_shift", 16'({busy, sr_s}), 16'({1'b1, 2'b10}));
    rst = 1'b1;
    @(negedge clk);
    check("midrst_idle", 16'({cmd_ready, busy, done, sr_s, sr_pin, sr_left, sr_right}),
          16'({1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0}));
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("midrst_no_done", 16'(dones), 16'd0);

    // randomized commands against the arithmetic reference
    for (int t = 0; t < 40; t++) begin
      rd = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rf = 1'($urandom_range(0, 1));
      rn = 3'($urandom_range(0, 7));
      rdat = 4'($urandom_range(0, 15));
      run_cmd(rd, rr, rf, rn, rdat, ref_result(rd, rr, rf, int'(rn), rdat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
